regfile_wb_arbiter: RTL and testbench

Two-requester write-back arbiter for the pipeline register file's single write port. The ALU write-back path (A) and the load/memory write-back path (B) each present a destination register and data with a valid/ready handshake. The block grants at most one request per cycle using round-robin on contention. It drives the register file's `reg_write` / `rd` / `data_rd` inputs from a one-cycle output register. It sits between the WB stage and the register file and also keeps a saturating count of committed writes.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arb2.sv | 29 ++
 rtl/regfile_wb_arbiter.sv | 61 ++++++
 tb/tb_regfile_wb_arbiter.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and defaults for the register-file write-back path.
// Included by the arbiter top and its round-robin grant generator.
package regfile_pkg;

   localparam int DATA_WIDTH_DEF = 20;
   localparam int REG_NUMBER_DEF = 5;

   typedef struct packed {
      logic [REG_NUMBER_DEF-1:0] rd;
      logic [DATA_WIDTH_DEF-1:0] data;
   } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant generator; req[0]/gnt[0] is A, req[1]/gnt[1] is B.
// last_b remembers the most recent winner so a tie goes to the other side.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_b;

   always_comb begin
      gnt = 2'b00;
      if (!rst) begin
         gnt[0] = req[0] & (~req[1] | last_b);
         gnt[1] = req[1] & (~req[0] | ~last_b);
      end
   end

   // Out of reset A wins the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_b <= 1'b1;
      end else if (|gnt) begin
         last_b <= gnt[1];
      end
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port: ALU (A)
// and load (B) requesters, registered write stage and saturating counter.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int REG_NUMBER = REG_NUMBER_DEF,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [REG_NUMBER-1:0] a_rd,
   input  logic [DATA_WIDTH-1:0] a_data,
   output logic                  a_ready,
   input  logic                  b_valid,
   input  logic [REG_NUMBER-1:0] b_rd,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic                  b_ready,
   output logic                  reg_write,
   output logic [REG_NUMBER-1:0] rd,
   output logic [DATA_WIDTH-1:0] data_rd,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   logic [1:0]            gnt;
   logic                  xfer;
   logic [REG_NUMBER-1:0] sel_rd;
   logic [DATA_WIDTH-1:0] sel_data;

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req ({b_valid, a_valid}),
      .gnt (gnt)
   );

   assign a_ready  = gnt[0];
   assign b_ready  = gnt[1];
   assign xfer     = |gnt;
   assign sel_rd   = gnt[1] ? b_rd : a_rd;
   assign sel_data = gnt[1] ? b_data : a_data;

   // x0 writes are consumed but never reach the register file.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write <= 1'b0;
         rd        <= '0;
         data_rd   <= '0;
         wr_count  <= '0;
      end else begin
         reg_write <= xfer && (sel_rd != '0);
         rd        <= xfer ? sel_rd : '0;
         data_rd   <= xfer ? sel_data : '0;
         if (reg_write && (wr_count != {CNT_WIDTH{1'b1}})) begin
            wr_count <= wr_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, then random traffic
// against a reference model; a 4-bit-counter copy exercises saturation.
module tb_regfile_wb_arbiter;
   import regfile_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        a_valid = 1'b0;
   logic [4:0]  a_rd = '0;
   logic [19:0] a_data = '0;
   logic        b_valid = 1'b0;
   logic [4:0]  b_rd = '0;
   logic [19:0] b_data = '0;
   logic        a_ready, b_ready, reg_write;
   logic [4:0]  rd;
   logic [19:0] data_rd;
   logic [15:0] wr_count;
   logic        s_a_ready, s_b_ready, s_reg_write;
   logic [4:0]  s_rd;
   logic [19:0] s_data_rd;
   logic [3:0]  s_wr_count;

   always #5 clk = ~clk;

   regfile_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
      .reg_write(reg_write), .rd(rd), .data_rd(data_rd),
      .wr_count(wr_count)
   );

   regfile_wb_arbiter #(.CNT_WIDTH(4)) dut_s (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(s_a_ready),
      .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(s_b_ready),
      .reg_write(s_reg_write), .rd(s_rd), .data_rd(s_data_rd),
      .wr_count(s_wr_count)
   );

   typedef struct {
      logic        rst;
      logic        av;
      logic [4:0]  ard;
      logic [19:0] ad;
      logic        bv;
      logic [4:0]  brd;
      logic [19:0] bd;
      logic        ear;
      logic        ebr;
      logic        ewe;
      logic [4:0]  erd;
      logic [19:0] ed;
      logic [15:0] ecnt;
   } vec_t;

   vec_t tbl[19];
   int   n_chk = 0;
   int   n_err = 0;

   // Reference model: who gets the next tie, the write stage, counters.
   bit          m_prio_a = 1'b1;
   bit          m_we = 1'b0;
   logic [4:0]  m_rd = '0;
   logic [19:0] m_data = '0;
   int          m_cnt = 0;
   int          m_cnt_s = 0;

   function automatic vec_t mk(
      input logic r, av, input logic [4:0] ard, input logic [19:0] ad,
      input logic bv, input logic [4:0] brd, input logic [19:0] bd,
      input logic ear, ebr, ewe, input logic [4:0] erd,
      input logic [19:0] ed, input logic [15:0] ecnt);
      vec_t v;
      v.rst = r; v.av = av; v.ard = ard; v.ad = ad;
      v.bv = bv; v.brd = brd; v.bd = bd;
      v.ear = ear; v.ebr = ebr; v.ewe = ewe;
      v.erd = erd; v.ed = ed; v.ecnt = ecnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   // Inputs are already driven (just after a falling edge).
   task automatic cycle(input bit use_tbl, input vec_t v,
                        output bit ga, output bit gb);
      #1;
      ga = 1'b0;
      gb = 1'b0;
      if (!rst) begin
         if (a_valid && b_valid) begin
            ga = m_prio_a;
            gb = !m_prio_a;
         end else begin
            ga = a_valid;
            gb = b_valid;
         end
      end
      if (use_tbl) begin
         chk("a_ready", {31'd0, a_ready}, {31'd0, v.ear});
         chk("b_ready", {31'd0, b_ready}, {31'd0, v.ebr});
      end else begin
         chk("a_ready", {31'd0, a_ready}, {31'd0, ga});
         chk("b_ready", {31'd0, b_ready}, {31'd0, gb});
      end
      @(posedge clk);
      if (rst) begin
         m_prio_a = 1'b1;
         m_we = 1'b0; m_rd = '0; m_data = '0;
         m_cnt = 0; m_cnt_s = 0;
      end else begin
         if (m_we) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_cnt_s < 15) m_cnt_s++;
         end
         if (ga || gb) begin
            m_rd   = ga ? a_rd : b_rd;
            m_data = ga ? a_data : b_data;
            m_we   = (m_rd != 0);
            m_prio_a = gb;
         end else begin
            m_we = 1'b0; m_rd = '0; m_data = '0;
         end
      end
      #1;
      if (use_tbl) begin
         chk("reg_write", {31'd0, reg_write}, {31'd0, v.ewe});
         chk("rd", {27'd0, rd}, {27'd0, v.erd});
         chk("data_rd", {12'd0, data_rd}, {12'd0, v.ed});
         chk("wr_count", {16'd0, wr_count}, {16'd0, v.ecnt});
      end else begin
         chk("reg_write", {31'd0, reg_write}, {31'd0, m_we});
         chk("rd", {27'd0, rd}, {27'd0, m_rd});
         chk("data_rd", {12'd0, data_rd}, {12'd0, m_data});
         chk("wr_count", {16'd0, wr_count}, m_cnt);
         chk("wr_count_sat4", {28'd0, s_wr_count}, m_cnt_s);
      end
      @(negedge clk);
   endtask

   initial begin
      vec_t v0;
      bit   ga, gb;
      bit   pa = 1'b0, pb = 1'b0;

      tbl[0]  = mk(1,0,0,0,       0,0,0,       0,0,0,0,0,0);
      tbl[1]  = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,0);
      tbl[2]  = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,0);
      tbl[3]  = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,0);
      tbl[4]  = mk(0,1,3,'h12345, 0,0,0,       1,0,1,3,'h12345,0);
      tbl[5]  = mk(0,0,0,0,       1,0,'hFFFFF, 0,1,0,0,'hFFFFF,1);
      tbl[6]  = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,1);
      tbl[7]  = mk(0,1,1,1,       1,2,2,       1,0,1,1,1,1);
      tbl[8]  = mk(0,0,0,0,       1,2,2,       0,1,1,2,2,2);
      tbl[9]  = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,3);
      tbl[10] = mk(0,1,4,'h44444, 0,0,0,       1,0,1,4,'h44444,3);
      tbl[11] = mk(0,1,7,'hAAAAA, 1,7,'h55555, 0,1,1,7,'h55555,4);
      tbl[12] = mk(0,1,7,'hAAAAA, 0,0,0,       1,0,1,7,'hAAAAA,5);
      tbl[13] = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,6);
      tbl[14] = mk(0,1,9,9,       1,10,'hA,    0,1,1,10,'hA,6);
      tbl[15] = mk(1,1,9,9,       1,11,'hB,    0,0,0,0,0,0);
      tbl[16] = mk(0,1,9,9,       1,11,'hB,    1,0,1,9,9,0);
      tbl[17] = mk(0,0,0,0,       1,11,'hB,    0,1,1,11,'hB,1);
      tbl[18] = mk(0,0,0,0,       0,0,0,       0,0,0,0,0,2);

      @(negedge clk);
      for (int i = 0; i < 19; i++) begin
         rst = tbl[i].rst;
         a_valid = tbl[i].av; a_rd = tbl[i].ard; a_data = tbl[i].ad;
         b_valid = tbl[i].bv; b_rd = tbl[i].brd; b_data = tbl[i].bd;
         cycle(1'b1, tbl[i], ga, gb);
      end

      // Random traffic: requesters hold until accepted, rare resets.
      v0 = tbl[0];
      for (int c = 0; c < 3000; c++) begin
         if (!pa && ($urandom_range(3) != 0)) begin
            pa = 1'b1;
            a_rd = 5'($urandom_range(31));
            a_data = 20'($urandom);
         end
         if (!pb && ($urandom_range(3) != 0)) begin
            pb = 1'b1;
            b_rd = 5'($urandom_range(31));
            b_data = 20'($urandom);
         end
         a_valid = pa;
         b_valid = pb;
         rst = ($urandom_range(199) == 0);
         cycle(1'b0, v0, ga, gb);
         if (ga) pa = 1'b0;
         if (gb) pb = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
